// File: rtl/cplx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cplx_pkg
// Brief    : Shared state type, default widths and signed-add overflow check
// Revision : 1.0
// ============================================================================
package cplx_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int IN_W_D  = 16;
  localparam int ACC_W_D = 24;

  // Operands share a sign but the result sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cplx_acc_add.sv
`default_nettype none
// ============================================================================
// Module   : cplx_acc_add
// Brief    : Real/imag accumulator adders with sign extension and overflow
// Revision : 1.0
// ============================================================================
module cplx_acc_add
  import cplx_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic signed [ACC_W-1:0] i_acc_re,
  input  logic signed [ACC_W-1:0] i_acc_im,
  input  logic signed [IN_W-1:0]  i_in_re,
  input  logic signed [IN_W-1:0]  i_in_im,
  output logic signed [ACC_W-1:0] o_sum_re,
  output logic signed [ACC_W-1:0] o_sum_im,
  output logic                    o_ovf_re,
  output logic                    o_ovf_im
);

  logic signed [ACC_W-1:0] w_ext_re;
  logic signed [ACC_W-1:0] w_ext_im;

  assign w_ext_re = {{(ACC_W-IN_W){i_in_re[IN_W-1]}}, i_in_re};
  assign w_ext_im = {{(ACC_W-IN_W){i_in_im[IN_W-1]}}, i_in_im};

  assign o_sum_re = i_acc_re + w_ext_re;
  assign o_sum_im = i_acc_im + w_ext_im;

  assign o_ovf_re = add_ovf(i_acc_re[ACC_W-1], w_ext_re[ACC_W-1], o_sum_re[ACC_W-1]);
  assign o_ovf_im = add_ovf(i_acc_im[ACC_W-1], w_ext_im[ACC_W-1], o_sum_im[ACC_W-1]);

endmodule
`default_nettype wire

// File: rtl/cplx_accum.sv
`default_nettype none
// ============================================================================
// Module   : cplx_accum
// Brief    : Frame accumulator of complex products with valid/ready output
// Revision : 1.0
// ============================================================================
module cplx_accum
  import cplx_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int LEN   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    VAL_IN,
  input  logic signed [IN_W-1:0]  REAL_IN,
  input  logic signed [IN_W-1:0]  IMAG_IN,
  output logic                    RDY_IN,
  output logic                    VAL_OUT,
  input  logic                    RDY_OUT,
  output logic signed [ACC_W-1:0] REAL_SUM,
  output logic signed [ACC_W-1:0] IMAG_SUM,
  output logic                    OVF_OUT,
  output logic [7:0]              FILL
);

  localparam logic [7:0] c_last = 8'(LEN - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic [7:0]              r_fill;
  logic                    r_ovf;
  logic signed [ACC_W-1:0] r_real_sum;
  logic signed [ACC_W-1:0] r_imag_sum;
  logic                    r_ovf_out;

  logic signed [ACC_W-1:0] w_sum_re;
  logic signed [ACC_W-1:0] w_sum_im;
  logic                    w_ovf_re;
  logic                    w_ovf_im;
  logic                    w_accept;
  logic                    w_frame_done;

  cplx_acc_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc_re (r_acc_re),
    .i_acc_im (r_acc_im),
    .i_in_re  (REAL_IN),
    .i_in_im  (IMAG_IN),
    .o_sum_re (w_sum_re),
    .o_sum_im (w_sum_im),
    .o_ovf_re (w_ovf_re),
    .o_ovf_im (w_ovf_im)
  );

  assign w_accept     = VAL_IN && RDY_IN;
  // Accumulators and FILL are zero in HOLD, so a HOLD accept starts a new frame.
  assign w_frame_done = w_accept && (r_fill == c_last);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: if (w_frame_done) w_state_nxt = HOLD;
      HOLD: begin
        if (w_frame_done)  w_state_nxt = HOLD;
        else if (RDY_OUT)  w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    RDY_IN  = 1'b1;
    VAL_OUT = 1'b0;
    if (r_state == HOLD) begin
      RDY_IN  = RDY_OUT;
      VAL_OUT = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_fill     <= '0;
      r_ovf      <= 1'b0;
      r_real_sum <= '0;
      r_imag_sum <= '0;
      r_ovf_out  <= 1'b0;
    end else if (w_accept) begin
      if (w_frame_done) begin
        r_real_sum <= w_sum_re;
        r_imag_sum <= w_sum_im;
        r_ovf_out  <= r_ovf | w_ovf_re | w_ovf_im;
        r_acc_re   <= '0;
        r_acc_im   <= '0;
        r_fill     <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_acc_re   <= w_sum_re;
        r_acc_im   <= w_sum_im;
        r_fill     <= r_fill + 8'd1;
        r_ovf      <= r_ovf | w_ovf_re | w_ovf_im;
      end
    end
  end

  assign REAL_SUM = r_real_sum;
  assign IMAG_SUM = r_imag_sum;
  assign OVF_OUT  = r_ovf_out;
  assign FILL     = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_cplx_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_cplx_accum
// Brief    : Directed bench for cplx_accum over LEN=4, 2, 1 and a narrow ACC_W
// Revision : 1.0
// ============================================================================
module tb_cplx_accum;

  logic               clk;
  logic               rst;
  logic               val_in;
  logic signed [15:0] real_in;
  logic signed [15:0] imag_in;
  logic               rdy_out;

  logic rdy_4, val_4, ovf_4; logic signed [23:0] re_4, im_4; logic [7:0] fill_4;
  logic rdy_2, val_2, ovf_2; logic signed [23:0] re_2, im_2; logic [7:0] fill_2;
  logic rdy_o, val_o, ovf_o; logic signed [16:0] re_o, im_o; logic [7:0] fill_o;
  logic rdy_1, val_1, ovf_1; logic signed [23:0] re_1, im_1; logic [7:0] fill_1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cplx_accum #(.IN_W(16), .ACC_W(24), .LEN(4)) u_dut4 (
    .CLK(clk), .RST(rst), .VAL_IN(val_in), .REAL_IN(real_in), .IMAG_IN(imag_in),
    .RDY_IN(rdy_4), .VAL_OUT(val_4), .RDY_OUT(rdy_out), .REAL_SUM(re_4),
    .IMAG_SUM(im_4), .OVF_OUT(ovf_4), .FILL(fill_4));

  cplx_accum #(.IN_W(16), .ACC_W(24), .LEN(2)) u_dut2 (
    .CLK(clk), .RST(rst), .VAL_IN(val_in), .REAL_IN(real_in), .IMAG_IN(imag_in),
    .RDY_IN(rdy_2), .VAL_OUT(val_2), .RDY_OUT(rdy_out), .REAL_SUM(re_2),
    .IMAG_SUM(im_2), .OVF_OUT(ovf_2), .FILL(fill_2));

  cplx_accum #(.IN_W(16), .ACC_W(17), .LEN(4)) u_dut_ovf (
    .CLK(clk), .RST(rst), .VAL_IN(val_in), .REAL_IN(real_in), .IMAG_IN(imag_in),
    .RDY_IN(rdy_o), .VAL_OUT(val_o), .RDY_OUT(rdy_out), .REAL_SUM(re_o),
    .IMAG_SUM(im_o), .OVF_OUT(ovf_o), .FILL(fill_o));

  cplx_accum #(.IN_W(16), .ACC_W(24), .LEN(1)) u_dut1 (
    .CLK(clk), .RST(rst), .VAL_IN(val_in), .REAL_IN(real_in), .IMAG_IN(imag_in),
    .RDY_IN(rdy_1), .VAL_OUT(val_1), .RDY_OUT(rdy_out), .REAL_SUM(re_1),
    .IMAG_SUM(im_1), .OVF_OUT(ovf_1), .FILL(fill_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are read 1 time unit later.
  task automatic drive(input logic v, input int re, input int im);
    @(negedge clk);
    val_in  = v;
    real_in = 16'(re);
    imag_in = 16'(im);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; val_in = 1'b0; rdy_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; val_in = 1'b0; real_in = '0; imag_in = '0; rdy_out = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++; if (val_4 !== 1'b0)  $display("FAIL reset_val got %0b exp 0", val_4); else pass_cnt++;
    total_cnt++; if (re_4 !== 24'sd0) $display("FAIL reset_real got %0d exp 0", re_4); else pass_cnt++;
    total_cnt++; if (im_4 !== 24'sd0) $display("FAIL reset_imag got %0d exp 0", im_4); else pass_cnt++;
    total_cnt++; if (ovf_4 !== 1'b0)  $display("FAIL reset_ovf got %0b exp 0", ovf_4); else pass_cnt++;
    total_cnt++; if (fill_4 !== 8'd0) $display("FAIL reset_fill got %0d exp 0", fill_4); else pass_cnt++;
    total_cnt++; if (rdy_4 !== 1'b1)  $display("FAIL reset_rdy_in got %0b exp 1", rdy_4); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    rdy_out = 1'b1;
    drive(1, 100, -50);
    drive(1, 200, 30);
    total_cnt++; if (fill_4 !== 8'd1) $display("FAIL basic_fill1 got %0d exp 1", fill_4); else pass_cnt++;
    drive(1, -300, 20);
    drive(1, 1, 1);
    total_cnt++; if (fill_4 !== 8'd3) $display("FAIL basic_fill3 got %0d exp 3", fill_4); else pass_cnt++;
    total_cnt++; if (val_4 !== 1'b0)  $display("FAIL basic_val_early got %0b exp 0", val_4); else pass_cnt++;
    drive(0, 0, 0);
    total_cnt++; if (val_4 !== 1'b1)  $display("FAIL basic_val got %0b exp 1", val_4); else pass_cnt++;
    total_cnt++; if (re_4 !== 24'sd1) $display("FAIL basic_real got %0d exp 1", re_4); else pass_cnt++;
    total_cnt++; if (im_4 !== 24'sd1) $display("FAIL basic_imag got %0d exp 1", im_4); else pass_cnt++;
    total_cnt++; if (ovf_4 !== 1'b0)  $display("FAIL basic_ovf got %0b exp 0", ovf_4); else pass_cnt++;
    total_cnt++; if (fill_4 !== 8'd0) $display("FAIL basic_fill_hold got %0d exp 0", fill_4); else pass_cnt++;
    drive(0, 0, 0);
    total_cnt++; if (val_4 !== 1'b0)  $display("FAIL basic_val_drop got %0b exp 0", val_4); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_out = 1'b0;
    drive(1, 100, -50);
    drive(1, 200, 30);
    drive(1, -300, 20);
    drive(1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1000, 1000);
      total_cnt++; if (val_4 !== 1'b1)  $display("FAIL stall_val[%0d] got %0b exp 1", i, val_4); else pass_cnt++;
      total_cnt++; if (rdy_4 !== 1'b0)  $display("FAIL stall_rdy_in[%0d] got %0b exp 0", i, rdy_4); else pass_cnt++;
      total_cnt++; if (re_4 !== 24'sd1) $display("FAIL stall_real[%0d] got %0d exp 1", i, re_4); else pass_cnt++;
      total_cnt++; if (im_4 !== 24'sd1) $display("FAIL stall_imag[%0d] got %0d exp 1", i, im_4); else pass_cnt++;
    end
    @(negedge clk);
    rdy_out = 1'b1;
    #1;
    total_cnt++; if (rdy_4 !== 1'b1) $display("FAIL release_rdy_in got %0b exp 1", rdy_4); else pass_cnt++;
    drive(1, 2, 3);
    total_cnt++; if (val_4 !== 1'b0)  $display("FAIL release_val got %0b exp 0", val_4); else pass_cnt++;
    total_cnt++; if (fill_4 !== 8'd1) $display("FAIL release_fill got %0d exp 1", fill_4); else pass_cnt++;
    drive(1, 2, 3);
    drive(1, 2, 3);
    drive(0, 0, 0);
    total_cnt++; if (val_4 !== 1'b1)     $display("FAIL bp_frame2_val got %0b exp 1", val_4); else pass_cnt++;
    total_cnt++; if (re_4 !== 24'sd1006) $display("FAIL bp_frame2_real got %0d exp 1006", re_4); else pass_cnt++;
    total_cnt++; if (im_4 !== 24'sd1009) $display("FAIL bp_frame2_imag got %0d exp 1009", im_4); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic       e_val;
    logic [7:0] e_fill;
    do_reset();
    rdy_out = 1'b1;
    drive(1, 5, 5);
    total_cnt++; if (fill_2 !== 8'd0) $display("FAIL b2b_fill0 got %0d exp 0", fill_2); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      e_val  = (k % 2 == 0);
      e_fill = 8'(k % 2);
      total_cnt++; if (val_2 !== e_val)   $display("FAIL b2b_val[%0d] got %0b exp %0b", k, val_2, e_val); else pass_cnt++;
      total_cnt++; if (fill_2 !== e_fill) $display("FAIL b2b_fill[%0d] got %0d exp %0d", k, fill_2, e_fill); else pass_cnt++;
      if (e_val) begin
        total_cnt++; if (re_2 !== 24'sd10) $display("FAIL b2b_real[%0d] got %0d exp 10", k, re_2); else pass_cnt++;
        total_cnt++; if (im_2 !== 24'sd10) $display("FAIL b2b_imag[%0d] got %0d exp 10", k, im_2); else pass_cnt++;
      end
    end
    val_in = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    rdy_out = 1'b1;
    repeat (4) drive(1, 32767, 0);
    drive(0, 0, 0);
    total_cnt++; if (val_o !== 1'b1)    $display("FAIL ovf_val got %0b exp 1", val_o); else pass_cnt++;
    total_cnt++; if (re_o !== -17'sd4)  $display("FAIL ovf_real got %0d exp -4", re_o); else pass_cnt++;
    total_cnt++; if (im_o !== 17'sd0)   $display("FAIL ovf_imag got %0d exp 0", im_o); else pass_cnt++;
    total_cnt++; if (ovf_o !== 1'b1)    $display("FAIL ovf_flag got %0b exp 1", ovf_o); else pass_cnt++;
    repeat (4) drive(1, 1, 1);
    drive(0, 0, 0);
    total_cnt++; if (re_o !== 17'sd4)   $display("FAIL ovf_next_real got %0d exp 4", re_o); else pass_cnt++;
    total_cnt++; if (im_o !== 17'sd4)   $display("FAIL ovf_next_imag got %0d exp 4", im_o); else pass_cnt++;
    total_cnt++; if (ovf_o !== 1'b0)    $display("FAIL ovf_next_flag got %0b exp 0", ovf_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    rdy_out = 1'b1;
    drive(1, 7, 7);
    drive(1, 7, 7);
    drive(0, 0, 0);
    total_cnt++; if (fill_4 !== 8'd2) $display("FAIL midrst_fill_pre got %0d exp 2", fill_4); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (fill_4 !== 8'd0) $display("FAIL midrst_fill_post got %0d exp 0", fill_4); else pass_cnt++;
    repeat (4) drive(1, 1, 2);
    drive(0, 0, 0);
    total_cnt++; if (val_4 !== 1'b1)  $display("FAIL midrst_val got %0b exp 1", val_4); else pass_cnt++;
    total_cnt++; if (re_4 !== 24'sd4) $display("FAIL midrst_real got %0d exp 4", re_4); else pass_cnt++;
    total_cnt++; if (im_4 !== 24'sd8) $display("FAIL midrst_imag got %0d exp 8", im_4); else pass_cnt++;
  endtask

  task automatic test_len1();
    do_reset();
    rdy_out = 1'b1;
    drive(1, -3, 9);
    drive(1, 4, -4);
    total_cnt++; if (val_1 !== 1'b1)   $display("FAIL len1_val_a got %0b exp 1", val_1); else pass_cnt++;
    total_cnt++; if (rdy_1 !== 1'b1)   $display("FAIL len1_rdy_a got %0b exp 1", rdy_1); else pass_cnt++;
    total_cnt++; if (re_1 !== -24'sd3) $display("FAIL len1_real_a got %0d exp -3", re_1); else pass_cnt++;
    total_cnt++; if (im_1 !== 24'sd9)  $display("FAIL len1_imag_a got %0d exp 9", im_1); else pass_cnt++;
    drive(0, 0, 0);
    total_cnt++; if (val_1 !== 1'b1)   $display("FAIL len1_val_b got %0b exp 1", val_1); else pass_cnt++;
    total_cnt++; if (re_1 !== 24'sd4)  $display("FAIL len1_real_b got %0d exp 4", re_1); else pass_cnt++;
    total_cnt++; if (im_1 !== -24'sd4) $display("FAIL len1_imag_b got %0d exp -4", im_1); else pass_cnt++;
    total_cnt++; if (fill_1 !== 8'd0)  $display("FAIL len1_fill got %0d exp 0", fill_1); else pass_cnt++;
    drive(0, 0, 0);
    total_cnt++; if (val_1 !== 1'b0)   $display("FAIL len1_val_drop got %0b exp 0", val_1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_len1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
